imem_loader: RTL

//  Bootloader that writes the instruction-memory image that the CPU fetches.

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_loader_word_assembler.sv | 37 +++
 rtl/imem_loader.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory bootloader.
package imem_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_CNT_W     = 2;
    localparam int unsigned LEN_W          = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    // True while a download is in progress (CPU must be held).
    function automatic logic is_busy(input state_t s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// UART byte stream in, instruction-memory write port and status out.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic              overflow;

    modport master (
        output start, rx_data, rx_valid,
        input  wr_en, wr_addr, wr_data, cpu_hold, done, error, overflow
    );

    modport slave (
        input  start, rx_data, rx_valid,
        output wr_en, wr_addr, wr_data, cpu_hold, done, error, overflow
    );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs an MSB-first byte stream into 32-bit words; word_valid pulses once per word.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [31:0] word_out,
    output logic        word_valid
);

    logic [BYTE_CNT_W-1:0] cnt;
    logic [23:0]           shreg;

    // Left-shift packer; clr drops any partial word.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt        <= '0;
            shreg      <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (byte_valid) begin
                shreg <= {shreg[15:0], byte_in};
                cnt   <= cnt + BYTE_CNT_W'(1);
                if (cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1)) begin
                    word_out   <= {shreg, byte_in};
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Bootloader: receives a length-prefixed, XOR-checked image over UART and writes it to IMEM.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 160,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic           clk,
    input  logic           reset,
    imem_loader_if.slave   bus
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

    state_t             state, state_nxt;
    logic [LEN_W-1:0]   len, len_nxt;
    logic [ADDR_W-1:0]  word_cnt, word_cnt_nxt;
    logic [7:0]         acc, acc_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic               done, done_nxt;
    logic               error, error_nxt;
    logic               overflow, overflow_nxt;
    logic               cpu_hold;
    logic               asm_clr_c;
    logic               timeout_c;
    logic [LEN_W-1:0]   len_rx_c;
    logic [31:0]        word;
    logic               word_valid;

    assign len_rx_c  = {len[15:8], bus.rx_data};
    assign timeout_c = is_busy(state) && !bus.rx_valid && (timer == TMR_W'(TIMEOUT_CYC - 1));

    word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clr        (asm_clr_c),
        .byte_in    (bus.rx_data),
        .byte_valid (bus.rx_valid && (state == ST_DATA)),
        .word_out   (word),
        .word_valid (word_valid)
    );

    // State, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            len      <= '0;
            word_cnt <= '0;
            acc      <= '0;
            timer    <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            overflow <= 1'b0;
            cpu_hold <= 1'b0;
        end else begin
            state    <= state_nxt;
            len      <= len_nxt;
            word_cnt <= word_cnt_nxt;
            acc      <= acc_nxt;
            timer    <= timer_nxt;
            done     <= done_nxt;
            error    <= error_nxt;
            overflow <= overflow_nxt;
            cpu_hold <= is_busy(state_nxt);
        end
    end

    // Next-state, frame parsing, checksum and inter-byte timeout.
    always_comb begin
        state_nxt    = state;
        len_nxt      = len;
        word_cnt_nxt = word_cnt;
        acc_nxt      = acc;
        timer_nxt    = timer;
        done_nxt     = done;
        error_nxt    = error;
        overflow_nxt = overflow;
        asm_clr_c    = 1'b0;

        if (is_busy(state)) begin
            timer_nxt = bus.rx_valid ? '0 : timer + TMR_W'(1);
        end

        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (bus.start) begin
                    state_nxt    = ST_LEN_HI;
                    len_nxt      = '0;
                    word_cnt_nxt = '0;
                    acc_nxt      = '0;
                    timer_nxt    = '0;
                    done_nxt     = 1'b0;
                    error_nxt    = 1'b0;
                    overflow_nxt = 1'b0;
                    asm_clr_c    = 1'b1;
                end
            end
            ST_LEN_HI: begin
                if (bus.rx_valid) begin
                    len_nxt   = {bus.rx_data, 8'h00};
                    state_nxt = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (bus.rx_valid) begin
                    len_nxt = len_rx_c;
                    if (len_rx_c > LEN_W'(MEM_WORDS)) begin
                        state_nxt    = ST_ERR;
                        error_nxt    = 1'b1;
                        overflow_nxt = 1'b1;
                    end else if (len_rx_c == '0) begin
                        state_nxt = ST_CSUM;
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (bus.rx_valid) begin
                    acc_nxt = acc ^ bus.rx_data;
                end
                // The address holds at N-1 after the final write.
                if (word_valid) begin
                    if (LEN_W'(word_cnt) == len - LEN_W'(1)) begin
                        state_nxt = ST_CSUM;
                    end else begin
                        word_cnt_nxt = word_cnt + ADDR_W'(1);
                    end
                end
            end
            ST_CSUM: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == acc) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_ERR;
                        error_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (timeout_c) begin
            state_nxt    = ST_ERR;
            error_nxt    = 1'b1;
            overflow_nxt = 1'b0;
            asm_clr_c    = 1'b1;
        end
    end

    assign bus.wr_en    = word_valid;
    assign bus.wr_data  = word;
    assign bus.wr_addr  = word_cnt;
    assign bus.cpu_hold = cpu_hold;
    assign bus.done     = done;
    assign bus.error    = error;
    assign bus.overflow = overflow;

endmodule
